// File: rtl/clause_load_controller_pkg.sv
// -----------------------------------------------------------------------------
// clause_solver_pkg
// Shared definitions for the clause-register loading path of the MCMC
// constraints solver.
//   clause_state_t : controller state encoding (IDLE, LOAD, LOADED, SCAN)
//   coeff_width()  : width of one packed clause coefficient word
//   index_width()  : width of a clause index
//   onehot_bit()   : one bit of a one-hot decode of a clause index
// -----------------------------------------------------------------------------
package clause_solver_pkg;

    // Controller states. LOADED is the only state from which a scan can begin.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_LOADED = 2'd2,
        ST_SCAN   = 2'd3
    } clause_state_t;

    // One clause word packs every integer coefficient of the clause.
    function automatic int coeff_width(input int bits_per_variable, input int variables_per_clause);
        return bits_per_variable * variables_per_clause;
    endfunction

    // Clause index width; never narrower than one bit.
    function automatic int index_width(input int clauses);
        return (clauses > 1) ? $clog2(clauses) : 1;
    endfunction

    // Bit 'position' of the one-hot decode of 'index'. Evaluated per bit so
    // the caller can build a decode of any width with a generate loop.
    function automatic logic onehot_bit(input int unsigned index, input int unsigned position);
        return index == position;
    endfunction

endpackage

// File: rtl/clause_load_controller_if.sv
// -----------------------------------------------------------------------------
// clause_load_controller_if
// Bundles the host loader, clause-register bank and evaluator signals of
// clause_load_controller.
//   modport slave  : the controller side (receives commands, drives status)
//   modport master : the host / evaluator side
// Signals:
//   in_load_start, in_coeff_valid, in_coeff_data        host load requests
//   out_coeff_ready                                     load handshake ready
//   out_clause_coefficients, out_clause_write_enable    clause bank write port
//   out_load_done                                       bank holds a valid set
//   in_scan_start, in_scan_ready                        evaluator scan control
//   out_scan_valid, out_scan_index, out_scan_last       clause index stream
//   out_busy                                            LOAD or SCAN in progress
//   out_load_overflow                                   only with CLAUSE_LOAD_OVERFLOW_EN
// -----------------------------------------------------------------------------
interface clause_load_controller_if
    import clause_solver_pkg::*;
#(
    parameter int BIT_WIDTH_OF_INTEGER_VARIABLE = 2,
    parameter int NUMBER_OF_INTEGER_VARIABLES   = 2,
    parameter int NUMBER_OF_CLAUSES             = 4
);

    localparam int COEFF_W = coeff_width(BIT_WIDTH_OF_INTEGER_VARIABLE, NUMBER_OF_INTEGER_VARIABLES);
    localparam int IDX_W   = index_width(NUMBER_OF_CLAUSES);

    logic                         in_load_start;
    logic                         in_coeff_valid;
    logic [COEFF_W-1:0]           in_coeff_data;
    logic                         out_coeff_ready;
    logic [COEFF_W-1:0]           out_clause_coefficients;
    logic [NUMBER_OF_CLAUSES-1:0] out_clause_write_enable;
    logic                         out_load_done;
    logic                         in_scan_start;
    logic                         in_scan_ready;
    logic                         out_scan_valid;
    logic [IDX_W-1:0]             out_scan_index;
    logic                         out_scan_last;
    logic                         out_busy;
`ifdef CLAUSE_LOAD_OVERFLOW_EN
    logic                         out_load_overflow;
`endif

    modport slave (
        input  in_load_start,
        input  in_coeff_valid,
        input  in_coeff_data,
        input  in_scan_start,
        input  in_scan_ready,
        output out_coeff_ready,
        output out_clause_coefficients,
        output out_clause_write_enable,
        output out_load_done,
        output out_scan_valid,
        output out_scan_index,
        output out_scan_last,
        output out_busy
`ifdef CLAUSE_LOAD_OVERFLOW_EN
        , output out_load_overflow
`endif
    );

    modport master (
        output in_load_start,
        output in_coeff_valid,
        output in_coeff_data,
        output in_scan_start,
        output in_scan_ready,
        input  out_coeff_ready,
        input  out_clause_coefficients,
        input  out_clause_write_enable,
        input  out_load_done,
        input  out_scan_valid,
        input  out_scan_index,
        input  out_scan_last,
        input  out_busy
`ifdef CLAUSE_LOAD_OVERFLOW_EN
        , input out_load_overflow
`endif
    );

endinterface

// File: rtl/clause_load_controller_index_counter.sv
// -----------------------------------------------------------------------------
// clause_index_counter
// Mod-N clause index counter with enable, synchronous clear and a terminal
// flag marking index N-1. Used for both the load and the scan index.
// Ports:
//   in_clk       clock, rising edge
//   in_reset     asynchronous active-high reset (count -> 0)
//   in_clear     synchronous clear, wins over in_enable
//   in_enable    advance one index; wraps to 0 after N-1
//   out_count    current index
//   out_terminal current index is N-1
// -----------------------------------------------------------------------------
module clause_index_counter #(
    parameter int COUNT_MODULUS = 4,
    parameter int IDX_W         = 2
) (
    input  logic             in_clk,
    input  logic             in_reset,
    input  logic             in_clear,
    input  logic             in_enable,
    output logic [IDX_W-1:0] out_count,
    output logic             out_terminal
);

    logic [IDX_W-1:0] count_q;

    assign out_terminal = (count_q == IDX_W'(COUNT_MODULUS - 1));
    assign out_count    = count_q;

    // Clear has priority so a restart in the same cycle as an advance
    // always lands on index 0.
    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            count_q <= '0;
        end else if (in_clear) begin
            count_q <= '0;
        end else if (in_enable) begin
            count_q <= out_terminal ? '0 : count_q + IDX_W'(1);
        end
    end

endmodule

// File: rtl/clause_load_controller.sv
// -----------------------------------------------------------------------------
// clause_load_controller
// Sequences the clause-register bank of the MCMC constraints solver. Host
// coefficient words arrive on a valid/ready handshake and word k is written
// into clause register k. Once the bank is full, clause indices 0..N-1 are
// scanned out to the clause evaluator on request.
// Ports:
//   in_clk    clock, rising edge
//   in_reset  asynchronous active-high reset; returns to IDLE, bank invalid
//   bus       clause_load_controller_if.slave (load, bank and scan signals)
// Optional feature macro: CLAUSE_LOAD_OVERFLOW_EN adds the sticky
// bus.out_load_overflow flag for words offered while the bank is full.
// Without it, surplus words are simply ignored (ready stays low).
// -----------------------------------------------------------------------------
module clause_load_controller
    import clause_solver_pkg::*;
#(
    parameter int BIT_WIDTH_OF_INTEGER_VARIABLE = 2,
    parameter int NUMBER_OF_INTEGER_VARIABLES   = 2,
    parameter int NUMBER_OF_CLAUSES             = 4
) (
    input logic                      in_clk,
    input logic                      in_reset,
    clause_load_controller_if.slave  bus
);

    localparam int COEFF_W = coeff_width(BIT_WIDTH_OF_INTEGER_VARIABLE, NUMBER_OF_INTEGER_VARIABLES);
    localparam int IDX_W   = index_width(NUMBER_OF_CLAUSES);

    clause_state_t                state_q;
    clause_state_t                state_d;
    logic [IDX_W-1:0]             load_count;
    logic [IDX_W-1:0]             scan_count;
    logic                         load_terminal;
    logic                         scan_terminal;
    logic                         load_restart;
    logic                         word_accept;
    logic                         scan_begin;
    logic                         scan_handshake;
    logic                         coeff_ready;
    logic                         busy;
    logic                         scan_valid;
    logic [NUMBER_OF_CLAUSES-1:0] write_select;
    logic [NUMBER_OF_CLAUSES-1:0] write_enable_q;
    logic [COEFF_W-1:0]           coeff_q;
    logic                         load_done_q;

    // A load restart is honoured everywhere except SCAN, so an evaluator pass
    // never sees the bank change underneath it. A restart also swallows any
    // word offered in the same cycle, and beats a coincident scan request.
    assign load_restart   = bus.in_load_start && (state_q != ST_SCAN);
    assign word_accept    = (state_q == ST_LOAD) && bus.in_coeff_valid && !bus.in_load_start;
    assign scan_begin     = (state_q == ST_LOADED) && bus.in_scan_start && !bus.in_load_start;
    assign scan_handshake = (state_q == ST_SCAN) && bus.in_scan_ready;

    // The load counter leaves LOAD on its terminal word, so its wrap back to
    // 0 is never observed as a write target; a new load always clears it.
    clause_index_counter #(
        .COUNT_MODULUS (NUMBER_OF_CLAUSES),
        .IDX_W         (IDX_W)
    ) u_load_counter (
        .in_clk       (in_clk),
        .in_reset     (in_reset),
        .in_clear     (load_restart),
        .in_enable    (word_accept),
        .out_count    (load_count),
        .out_terminal (load_terminal)
    );

    // The scan counter wraps to 0 on the final handshake, which leaves the
    // index at 0 while the controller sits in LOADED.
    clause_index_counter #(
        .COUNT_MODULUS (NUMBER_OF_CLAUSES),
        .IDX_W         (IDX_W)
    ) u_scan_counter (
        .in_clk       (in_clk),
        .in_reset     (in_reset),
        .in_clear     (scan_begin),
        .in_enable    (scan_handshake),
        .out_count    (scan_count),
        .out_terminal (scan_terminal)
    );

    // One-hot write select for the clause register addressed by load_count.
    for (genvar k = 0; k < NUMBER_OF_CLAUSES; k++) begin : g_write_select
        assign write_select[k] = onehot_bit(32'(load_count), k);
    end

    // State register.
    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic plus the state-decoded handshake/status outputs.
    always_comb begin
        state_d     = state_q;
        coeff_ready = 1'b0;
        busy        = 1'b0;
        scan_valid  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_restart) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                coeff_ready = 1'b1;
                busy        = 1'b1;
                if (load_restart) begin
                    state_d = ST_LOAD;
                end else if (word_accept && load_terminal) begin
                    state_d = ST_LOADED;
                end
            end
            ST_LOADED: begin
                if (load_restart) begin
                    state_d = ST_LOAD;
                end else if (scan_begin) begin
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                busy       = 1'b1;
                scan_valid = 1'b1;
                if (scan_handshake && scan_terminal) begin
                    state_d = ST_LOADED;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bank write port: the accepted word and a single-cycle one-hot enable
    // are registered together so the bank captures them on the next edge.
    // The data stays put between writes. load_done rises one cycle after the
    // final write pulse (first edge spent in LOADED) and drops on a restart.
    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            write_enable_q <= '0;
            coeff_q        <= '0;
            load_done_q    <= 1'b0;
        end else begin
            write_enable_q <= word_accept ? write_select : '0;
            if (word_accept) begin
                coeff_q <= bus.in_coeff_data;
            end
            if (load_restart) begin
                load_done_q <= 1'b0;
            end else if (state_q == ST_LOADED) begin
                load_done_q <= 1'b1;
            end
        end
    end

`ifdef CLAUSE_LOAD_OVERFLOW_EN
    logic overflow_q;

    // Sticky record that the host offered a word while the bank was full.
    // Only a honoured load restart (or reset) clears it.
    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            overflow_q <= 1'b0;
        end else if (load_restart) begin
            overflow_q <= 1'b0;
        end else if (bus.in_coeff_valid && ((state_q == ST_LOADED) || (state_q == ST_SCAN))) begin
            overflow_q <= 1'b1;
        end
    end

    assign bus.out_load_overflow = overflow_q;
`endif

    assign bus.out_coeff_ready         = coeff_ready;
    assign bus.out_clause_coefficients = coeff_q;
    assign bus.out_clause_write_enable = write_enable_q;
    assign bus.out_load_done           = load_done_q;
    assign bus.out_scan_valid          = scan_valid;
    assign bus.out_scan_index          = scan_count;
    assign bus.out_scan_last           = scan_valid && scan_terminal;
    assign bus.out_busy                = busy;

endmodule

// File: tb/tb_clause_load_controller.sv
// -----------------------------------------------------------------------------
// tb_clause_load_controller
// Directed self-checking bench for clause_load_controller with N=4 clauses
// and 4-bit coefficient words. Honours CLAUSE_LOAD_OVERFLOW_EN when defined.
// -----------------------------------------------------------------------------
module tb_clause_load_controller;

    localparam int BW = 2;
    localparam int NV = 2;
    localparam int N  = 4;

    logic in_clk = 1'b0;
    logic in_reset;
    int   total = 0;
    int   bad   = 0;

    logic [3:0] words_first  [4] = '{4'd1, 4'd7, 4'd8, 4'd9};
    logic [3:0] words_second [4] = '{4'd2, 4'd4, 4'd6, 4'd8};

    clause_load_controller_if #(
        .BIT_WIDTH_OF_INTEGER_VARIABLE (BW),
        .NUMBER_OF_INTEGER_VARIABLES   (NV),
        .NUMBER_OF_CLAUSES             (N)
    ) bus ();

    clause_load_controller #(
        .BIT_WIDTH_OF_INTEGER_VARIABLE (BW),
        .NUMBER_OF_INTEGER_VARIABLES   (NV),
        .NUMBER_OF_CLAUSES             (N)
    ) dut (
        .in_clk   (in_clk),
        .in_reset (in_reset),
        .bus      (bus)
    );

    always #5 in_clk = ~in_clk;

    // Advance one clock and settle just past the rising edge.
    task automatic step();
        @(posedge in_clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic load_start, input logic coeff_valid,
                                  input logic [3:0] coeff_data, input logic scan_start,
                                  input logic scan_ready);
        bus.in_load_start  = load_start;
        bus.in_coeff_valid = coeff_valid;
        bus.in_coeff_data  = coeff_data;
        bus.in_scan_start  = scan_start;
        bus.in_scan_ready  = scan_ready;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_output({tag, "_ready"}, 32'(bus.out_coeff_ready), 0);
        check_output({tag, "_coeff"}, 32'(bus.out_clause_coefficients), 0);
        check_output({tag, "_we"}, 32'(bus.out_clause_write_enable), 0);
        check_output({tag, "_done"}, 32'(bus.out_load_done), 0);
        check_output({tag, "_svalid"}, 32'(bus.out_scan_valid), 0);
        check_output({tag, "_sindex"}, 32'(bus.out_scan_index), 0);
        check_output({tag, "_slast"}, 32'(bus.out_scan_last), 0);
        check_output({tag, "_busy"}, 32'(bus.out_busy), 0);
`ifdef CLAUSE_LOAD_OVERFLOW_EN
        check_output({tag, "_ovf"}, 32'(bus.out_load_overflow), 0);
`endif
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: sequence did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state
        in_reset = 1'b1;
        apply_stimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        step();
        step();
        check_idle_outputs("reset");
        in_reset = 1'b0;

        // Scan request in IDLE is ignored
        apply_stimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        step();
        check_output("idle_scan_valid", 32'(bus.out_scan_valid), 0);
        check_output("idle_scan_busy", 32'(bus.out_busy), 0);

        // Back-to-back load of 1,7,8,9
        apply_stimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        step();
        check_output("t1_ready", 32'(bus.out_coeff_ready), 1);
        check_output("t1_busy", 32'(bus.out_busy), 1);
        check_output("t1_done0", 32'(bus.out_load_done), 0);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b0, 1'b1, words_first[i], 1'b0, 1'b0);
            step();
            check_output("t1_we", 32'(bus.out_clause_write_enable), 32'(1 << i));
            check_output("t1_data", 32'(bus.out_clause_coefficients), 32'(words_first[i]));
            check_output("t1_ready_k", 32'(bus.out_coeff_ready), (i < 3) ? 1 : 0);
        end
        check_output("t1_done_not_yet", 32'(bus.out_load_done), 0);

        // Surplus fifth word while LOADED
        apply_stimulus(1'b0, 1'b1, 4'd5, 1'b0, 1'b0);
        step();
        check_output("t1_done1", 32'(bus.out_load_done), 1);
        check_output("surplus_we", 32'(bus.out_clause_write_enable), 0);
        check_output("surplus_data", 32'(bus.out_clause_coefficients), 9);
        check_output("surplus_ready", 32'(bus.out_coeff_ready), 0);
        check_output("surplus_busy", 32'(bus.out_busy), 0);
        apply_stimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        step();
        check_output("surplus_done_held", 32'(bus.out_load_done), 1);
        check_output("surplus_data_held", 32'(bus.out_clause_coefficients), 9);
`ifdef CLAUSE_LOAD_OVERFLOW_EN
        check_output("ovf_set", 32'(bus.out_load_overflow), 1);
        step();
        check_output("ovf_sticky", 32'(bus.out_load_overflow), 1);
`endif

        // Reload with gaps and a mid-load restart
        apply_stimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        step();
        check_output("t2_done_drop", 32'(bus.out_load_done), 0);
        check_output("t2_ready", 32'(bus.out_coeff_ready), 1);
`ifdef CLAUSE_LOAD_OVERFLOW_EN
        check_output("ovf_cleared", 32'(bus.out_load_overflow), 0);
`endif
        apply_stimulus(1'b0, 1'b1, 4'd3, 1'b0, 1'b0);
        step();
        check_output("t2_we_w0", 32'(bus.out_clause_write_enable), 1);
        check_output("t2_data_w0", 32'(bus.out_clause_coefficients), 3);
        apply_stimulus(1'b0, 1'b0, 4'd3, 1'b0, 1'b0);
        step();
        check_output("t2_gap_we", 32'(bus.out_clause_write_enable), 0);
        check_output("t2_gap_data", 32'(bus.out_clause_coefficients), 3);
        apply_stimulus(1'b0, 1'b1, 4'd4, 1'b0, 1'b0);
        step();
        check_output("t2_we_w1", 32'(bus.out_clause_write_enable), 2);
        check_output("t2_data_w1", 32'(bus.out_clause_coefficients), 4);
        apply_stimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        step();
        check_output("t2_restart_we", 32'(bus.out_clause_write_enable), 0);
        check_output("t2_restart_ready", 32'(bus.out_coeff_ready), 1);
        apply_stimulus(1'b0, 1'b1, 4'hA, 1'b0, 1'b0);
        step();
        check_output("t2_restart_target", 32'(bus.out_clause_write_enable), 1);
        check_output("t2_restart_data", 32'(bus.out_clause_coefficients), 32'hA);
        apply_stimulus(1'b0, 1'b1, 4'hB, 1'b0, 1'b0);
        step();
        check_output("t2_we_b", 32'(bus.out_clause_write_enable), 2);
        apply_stimulus(1'b0, 1'b0, 4'hB, 1'b0, 1'b0);
        step();
        check_output("t2_gap2_ready", 32'(bus.out_coeff_ready), 1);
        apply_stimulus(1'b0, 1'b1, 4'hC, 1'b0, 1'b0);
        step();
        check_output("t2_we_c", 32'(bus.out_clause_write_enable), 4);
        apply_stimulus(1'b0, 1'b1, 4'hD, 1'b0, 1'b0);
        step();
        check_output("t2_we_d", 32'(bus.out_clause_write_enable), 8);
        check_output("t2_data_d", 32'(bus.out_clause_coefficients), 32'hD);
        check_output("t2_ready_off", 32'(bus.out_coeff_ready), 0);
        apply_stimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        step();
        check_output("t2_done", 32'(bus.out_load_done), 1);

        // Full-speed scan
        apply_stimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        step();
        apply_stimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check_output("t3_valid", 32'(bus.out_scan_valid), 1);
            check_output("t3_index", 32'(bus.out_scan_index), 32'(i));
            check_output("t3_last", 32'(bus.out_scan_last), (i == 3) ? 1 : 0);
            check_output("t3_busy", 32'(bus.out_busy), 1);
            step();
        end
        check_output("t3_end_valid", 32'(bus.out_scan_valid), 0);
        check_output("t3_end_index", 32'(bus.out_scan_index), 0);
        check_output("t3_end_last", 32'(bus.out_scan_last), 0);
        check_output("t3_end_busy", 32'(bus.out_busy), 0);
        check_output("t3_end_done", 32'(bus.out_load_done), 1);

        // Scan with evaluator stall on index 2
        apply_stimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        step();
        apply_stimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        check_output("t4_index0", 32'(bus.out_scan_index), 0);
        step();
        check_output("t4_index1", 32'(bus.out_scan_index), 1);
        step();
        check_output("t4_index2", 32'(bus.out_scan_index), 2);
        apply_stimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        for (int j = 0; j < 3; j++) begin
            step();
            check_output("t4_hold_index", 32'(bus.out_scan_index), 2);
            check_output("t4_hold_valid", 32'(bus.out_scan_valid), 1);
            check_output("t4_hold_last", 32'(bus.out_scan_last), 0);
        end
        apply_stimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        step();
        check_output("t4_resume_index", 32'(bus.out_scan_index), 3);
        check_output("t4_resume_last", 32'(bus.out_scan_last), 1);
        step();
        check_output("t4_end_valid", 32'(bus.out_scan_valid), 0);

        // Load and scan requested together: load wins
        apply_stimulus(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
        step();
        check_output("t5_ready", 32'(bus.out_coeff_ready), 1);
        check_output("t5_no_scan", 32'(bus.out_scan_valid), 0);
        check_output("t5_busy", 32'(bus.out_busy), 1);
        check_output("t5_done_drop", 32'(bus.out_load_done), 0);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b0, 1'b1, words_second[i], 1'b0, 1'b0);
            step();
            check_output("t5_we", 32'(bus.out_clause_write_enable), 32'(1 << i));
        end
        apply_stimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        step();
        check_output("t5_done", 32'(bus.out_load_done), 1);
        apply_stimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        step();
        apply_stimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        check_output("t5_scan_index0", 32'(bus.out_scan_index), 0);
        step();
        check_output("t5_scan_index1", 32'(bus.out_scan_index), 1);

        // Load request during SCAN is ignored
        apply_stimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        step();
        check_output("t5_scan_load_ign_valid", 32'(bus.out_scan_valid), 1);
        check_output("t5_scan_load_ign_index", 32'(bus.out_scan_index), 1);
        check_output("t5_scan_load_ign_ready", 32'(bus.out_coeff_ready), 0);
        apply_stimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a scan
        #3;
        in_reset = 1'b1;
        #1;
        check_idle_outputs("async_reset");
        step();
        in_reset = 1'b0;
        step();
        check_output("post_reset_done", 32'(bus.out_load_done), 0);
        check_output("post_reset_busy", 32'(bus.out_busy), 0);
        check_output("post_reset_valid", 32'(bus.out_scan_valid), 0);

        $display("[TB] directed sequence complete");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
